// File: rtl/graph_pkg.sv
// graph_pkg: shared constants for the 26-node cartesian arena graph.
//   NUM_NODES  - number of graph nodes (node indices 0..NUM_NODES-1)
//   NODE_W     - width of a node index
//   COORD_W    - width of one grid coordinate
//   NODE_NONE  - index reported when no node sits at a coordinate
//   NODE_COORD - per-node {x, y} coordinate table, index 0 listed first
//   c2n_state_t - state encoding for the coordinate-to-node search FSM
// The forward node-to-coordinate map and the reverse lookup both read
// NODE_COORD from here, so the two directions cannot drift apart.
package graph_pkg;

    localparam int NUM_NODES = 26;
    localparam int NODE_W    = 5;
    localparam int COORD_W   = 3;

    localparam logic [NODE_W-1:0] NODE_NONE = 5'd31;
    localparam logic [NODE_W-1:0] LAST_IDX  = NODE_W'(NUM_NODES - 1);

    // Each entry is {x[5:3], y[2:0]}; octal literals read directly as "xy".
    // Ascending range so the first listed entry is node 0.
    localparam logic [0:NUM_NODES-1][2*COORD_W-1:0] NODE_COORD = {
        6'o00, 6'o20, 6'o30, 6'o31, 6'o70, 6'o40, 6'o60, 6'o11, 6'o32,
        6'o42, 6'o53, 6'o02, 6'o12, 6'o22, 6'o33, 6'o43, 6'o63, 6'o13,
        6'o24, 6'o25, 6'o34, 6'o35, 6'o44, 6'o64, 6'o65, 6'o45
    };

    typedef enum logic [1:0] {
        C2N_IDLE   = 2'd0,
        C2N_SEARCH = 2'd1,
        C2N_RESP   = 2'd2
    } c2n_state_t;

endpackage

// File: rtl/node_coord_rom.sv
// node_coord_rom: combinational lookup of a node's grid coordinate.
//   idx   in  NODE_W     node index (callers keep it below NUM_NODES)
//   coord out 2*COORD_W  packed {x, y} of that node
module node_coord_rom
    import graph_pkg::*;
(
    input  logic [NODE_W-1:0]    idx,
    output logic [2*COORD_W-1:0] coord
);

    assign coord = NODE_COORD[idx];

endmodule

// File: rtl/coord_to_node.sv
// coord_to_node: reverse lookup from an (x, y) grid coordinate to the graph
// node at that position, scanning the node table one entry per cycle.
//   clk, rst_n   clock; synchronous active-low reset
//   req_valid    in   request present
//   req_ready    out  block can accept a request (only while idle)
//   req_x, req_y in   query coordinate, sampled only at the accepting edge
//   resp_valid   out  response present, held until resp_ready
//   resp_ready   in   consumer accepts response
//   resp_node    out  matched node index, NODE_NONE on a miss
//   resp_found   out  1 = match, 0 = miss
//   dbg_state    out  current FSM state (c2n_state_t encoding)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds valid (and payload) until that edge; ready never
// depends combinationally on valid. Here req_ready and resp_valid are plain
// registers, and only one request is outstanding at a time.
module coord_to_node
    import graph_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [COORD_W-1:0] req_x,
    input  logic [COORD_W-1:0] req_y,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [NODE_W-1:0]  resp_node,
    output logic               resp_found,
    output logic [1:0]         dbg_state
);

    c2n_state_t            state;
    logic [NODE_W-1:0]     idx;
    logic [2*COORD_W-1:0]  query;
    logic [2*COORD_W-1:0]  rom_coord;

    node_coord_rom u_rom (
        .idx   (idx),
        .coord (rom_coord)
    );

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= C2N_IDLE;
            idx        <= '0;
            query      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_node  <= '0;
            resp_found <= 1'b0;
        end else begin
            case (state)
                C2N_IDLE: begin
                    if (req_valid) begin
                        query     <= {req_x, req_y};
                        idx       <= '0;
                        req_ready <= 1'b0;
                        state     <= C2N_SEARCH;
                    end
                end
                C2N_SEARCH: begin
                    // Entries are unique, so the first hit is the only hit.
                    // A miss always walks the whole table, even for
                    // coordinates that are obviously off the arena.
                    if (rom_coord == query) begin
                        resp_node  <= idx;
                        resp_found <= 1'b1;
                        resp_valid <= 1'b1;
                        state      <= C2N_RESP;
                    end else if (idx == LAST_IDX) begin
                        resp_node  <= NODE_NONE;
                        resp_found <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= C2N_RESP;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                C2N_RESP: begin
                    // req_ready rises only after the response edge, so no
                    // request is taken in the handshake cycle itself.
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= C2N_IDLE;
                    end
                end
                default: begin
                    state <= C2N_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coord_to_node.sv
// tb_coord_to_node: directed table-driven bench for coord_to_node.
module tb_coord_to_node;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_x;
    logic [2:0] req_y;
    logic       resp_valid;
    logic       resp_ready;
    logic [4:0] resp_node;
    logic       resp_found;
    logic [1:0] dbg_state;

    int total = 0;
    int bad   = 0;

    // Scoreboard of expected responses: {node, found}.
    logic [5:0] exp_q[$];

    // Independent copy of the arena node coordinates.
    int node_x [26] = '{0,2,3,3,7,4,6,1,3,4,5,0,1,2,3,4,6,1,2,2,3,3,4,6,6,4};
    int node_y [26] = '{0,0,0,1,0,0,0,1,2,2,3,2,2,2,3,3,3,3,4,5,4,5,4,4,5,5};

    typedef struct {
        logic [2:0] x;
        logic [2:0] y;
        int         node;
        int         found;
        int         lat;
        int         hold;
    } vec_t;

    vec_t vecs [6];

    coord_to_node dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_node  (resp_node),
        .resp_found (resp_found),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " req_ready"},  int'(req_ready),  1);
        chk({tag, " resp_valid"}, int'(resp_valid), 0);
        chk({tag, " resp_node"},  int'(resp_node),  0);
        chk({tag, " resp_found"}, int'(resp_found), 0);
        chk({tag, " state"},      int'(dbg_state),  0);
    endtask

    // ---------------- driver ----------------
    // Issues one query, measures latency from the accept edge, holds off
    // resp_ready for 'hold' cycles, then completes the response handshake.
    task automatic run_query(input string tag, input logic [2:0] x,
                             input logic [2:0] y, input int exp_node,
                             input int exp_found, input int exp_lat,
                             input int hold, input bit scramble);
        int n;
        int lat;
        logic [5:0] e;
        logic [4:0] held_node;

        exp_q.push_back({5'(exp_node), 1'(exp_found)});

        n = 0;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk({tag, " wait req_ready"}, 0, 1);

        req_valid = 1'b1;
        req_x     = x;
        req_y     = y;
        step();                      // accept edge
        req_valid = 1'b0;
        if (scramble) begin
            req_x = 3'd0;
            req_y = 3'd0;
        end

        lat = 0;
        while (!resp_valid && lat < 60) begin
            if (req_ready) chk({tag, " req_ready low in search"}, 1, 0);
            step();
            lat++;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " req_ready in resp"}, int'(req_ready), 0);

        e = exp_q.pop_front();
        chk({tag, " node"},  int'(resp_node),  int'(e[5:1]));
        chk({tag, " found"}, int'(resp_found), int'(e[0]));

        held_node = resp_node;
        for (int i = 0; i < hold; i++) begin
            step();
            chk({tag, " hold valid"}, int'(resp_valid), 1);
            chk({tag, " hold node"},  int'(resp_node),  int'(held_node));
        end

        resp_ready = 1'b1;
        step();                      // response handshake edge
        resp_ready = 1'b0;
        chk({tag, " valid after hs"}, int'(resp_valid), 0);
        chk({tag, " ready after hs"}, int'(req_ready),  1);
    endtask

    function automatic bit is_node(input int x, input int y);
        for (int k = 0; k < 26; k++)
            if (node_x[k] == x && node_y[k] == y) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- test ----------------
    initial begin
        int rx;
        int ry;
        int misses;
        int guard;

        vecs[0] = '{x: 3'd0, y: 3'd0, node: 0,  found: 1, lat: 1,  hold: 0};
        vecs[1] = '{x: 3'd3, y: 3'd1, node: 3,  found: 1, lat: 4,  hold: 0};
        vecs[2] = '{x: 3'd4, y: 3'd5, node: 25, found: 1, lat: 26, hold: 0};
        vecs[3] = '{x: 3'd5, y: 3'd0, node: 31, found: 0, lat: 26, hold: 0};
        vecs[4] = '{x: 3'd2, y: 3'd7, node: 31, found: 0, lat: 26, hold: 0};
        vecs[5] = '{x: 3'd6, y: 3'd4, node: 23, found: 1, lat: 24, hold: 10};

        req_valid  = 1'b0;
        req_x      = '0;
        req_y      = '0;
        resp_ready = 1'b0;
        rst_n      = 1'b0;

        apply_reset();
        chk_reset_outputs("reset");

        for (int i = 0; i < 6; i++)
            run_query($sformatf("vec%0d", i), vecs[i].x, vecs[i].y,
                      vecs[i].node, vecs[i].found, vecs[i].lat,
                      vecs[i].hold, 1'b0);

        // Inputs change during the search; the latched query must win.
        run_query("scramble", 3'd4, 3'd4, 22, 1, 23, 0, 1'b1);

        // Reset at idx=10 while searching for (4,5).
        req_valid = 1'b1;
        req_x     = 3'd4;
        req_y     = 3'd5;
        step();
        req_valid = 1'b0;
        repeat (10) step();
        chk("mid-search state", int'(dbg_state), 1);
        rst_n = 1'b0;
        step();
        chk_reset_outputs("abort");
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (resp_valid) chk("no resp after abort", 1, 0);
            step();
        end
        chk("idle after abort", int'(dbg_state), 0);
        run_query("after abort", 3'd1, 3'd1, 7, 1, 8, 0, 1'b0);

        // Every table coordinate maps back to its own index.
        for (int k = 0; k < 26; k++)
            run_query($sformatf("sweep%0d", k), 3'(node_x[k]), 3'(node_y[k]),
                      k, 1, k + 1, 0, 1'b0);

        // Random off-table coordinates all miss after a full scan.
        misses = 0;
        guard  = 0;
        while (misses < 10 && guard < 200) begin
            rx = $urandom_range(0, 7);
            ry = $urandom_range(0, 7);
            guard++;
            if (!is_node(rx, ry)) begin
                run_query($sformatf("miss(%0d,%0d)", rx, ry), 3'(rx), 3'(ry),
                          31, 0, 26, 0, 1'b0);
                misses++;
            end
        end

        chk("scoreboard drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
